// File: rtl/dsp_dry_splitter.sv
// Wet/dry splitter: forwards each sample to the effect chain and queues a dry
// copy that is released when the matching wet sample comes back.
module dsp_dry_splitter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [WIDTH-1:0]       pktIn_i,
    input  logic                   pktInChanged_i,
    input  logic                   pktWetChanged_i,
    input  logic                   clrFlags_i,
    output logic [WIDTH-1:0]       pktFx_o,
    output logic                   pktFxChanged_o,
    output logic [WIDTH-1:0]       pktDry_o,
    output logic                   pktDryPopped_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic             run_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;

    logic push_req;
    logic pop_req;
    logic full;
    logic empty;
    logic do_push;
    logic do_pop;
    logic ovf_set;
    logic unf_set;

    // Strobes are ignored until the edge after reset release has been seen.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign push_req = pktInChanged_i && run_q;
    assign pop_req  = pktWetChanged_i && run_q;
    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign do_pop   = pop_req && !empty;
    assign do_push  = push_req && (!full || pop_req);
    assign ovf_set  = push_req && full && !pop_req;
    assign unf_set  = pop_req && empty;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= pktIn_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level_q        <= '0;
            pktFx_o        <= '0;
            pktFxChanged_o <= 1'b0;
            pktDryPopped_o <= 1'b0;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            pktFxChanged_o <= push_req;
            if (push_req) begin
                pktFx_o <= pktIn_i;
            end

            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            pktDryPopped_o <= do_pop;

            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase

            // A new error outranks a coincident clear.
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (clrFlags_i) begin
                overflow_o <= 1'b0;
            end
            if (unf_set) begin
                underflow_o <= 1'b1;
            end else if (clrFlags_i) begin
                underflow_o <= 1'b0;
            end
        end
    end

    assign level_o  = level_q;
    assign pktDry_o = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_dsp_dry_splitter.sv
// Bench for dsp_dry_splitter: directed cases plus random traffic, checked
// every cycle against a queue-based model of the dry path.
module tb_dsp_dry_splitter;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int LW = $clog2(D) + 1;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic [W-1:0]  pktIn_i;
    logic          pktInChanged_i;
    logic          pktWetChanged_i;
    logic          clrFlags_i;
    logic [W-1:0]  pktFx_o;
    logic          pktFxChanged_o;
    logic [W-1:0]  pktDry_o;
    logic          pktDryPopped_o;
    logic [LW-1:0] level_o;
    logic          overflow_o;
    logic          underflow_o;

    int vectors = 0;
    int errors  = 0;

    dsp_dry_splitter #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .pktIn_i         (pktIn_i),
        .pktInChanged_i  (pktInChanged_i),
        .pktWetChanged_i (pktWetChanged_i),
        .clrFlags_i      (clrFlags_i),
        .pktFx_o         (pktFx_o),
        .pktFxChanged_o  (pktFxChanged_o),
        .pktDry_o        (pktDry_o),
        .pktDryPopped_o  (pktDryPopped_o),
        .level_o         (level_o),
        .overflow_o      (overflow_o),
        .underflow_o     (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: dry FIFO as a plain queue.
    logic [W-1:0] q[$];
    logic [W-1:0] m_fx;
    logic         m_fxchg;
    logic         m_popped;
    logic         m_ovf;
    logic         m_unf;
    logic         m_run;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q.delete();
            m_fx     = '0;
            m_fxchg  = 1'b0;
            m_popped = 1'b0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_run    = 1'b0;
        end else begin
            automatic int   sz = q.size();
            automatic logic p  = pktInChanged_i && m_run;
            automatic logic w  = pktWetChanged_i && m_run;
            m_fxchg  = p;
            m_popped = 1'b0;
            if (p) m_fx = pktIn_i;
            if (p && sz == D && !w) m_ovf = 1'b1;
            else if (clrFlags_i && m_run) m_ovf = 1'b0;
            if (w && sz == 0) m_unf = 1'b1;
            else if (clrFlags_i && m_run) m_unf = 1'b0;
            if (w && sz > 0) begin
                void'(q.pop_front());
                m_popped = 1'b1;
            end
            if (p && (sz < D || w)) q.push_back(pktIn_i);
            m_run = 1'b1;
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    always @(negedge clk_i) begin
        automatic logic [W-1:0] e_dry = (q.size() > 0) ? q[0] : '0;
        vectors++;
        chk("fx",       32'(pktFx_o),        32'(m_fx));
        chk("fxchg",    32'(pktFxChanged_o), 32'(m_fxchg));
        chk("dry",      32'(pktDry_o),       32'(e_dry));
        chk("popped",   32'(pktDryPopped_o), 32'(m_popped));
        chk("level",    32'(level_o),        32'(q.size()));
        chk("overflow", 32'(overflow_o),     32'(m_ovf));
        chk("underflow",32'(underflow_o),    32'(m_unf));
    end

    task automatic drive(logic s, logic [W-1:0] v, logic w, logic c);
        pktInChanged_i  = s;
        pktIn_i         = v;
        pktWetChanged_i = w;
        clrFlags_i      = c;
        @(posedge clk_i);
        #2;
        pktInChanged_i  = 1'b0;
        pktWetChanged_i = 1'b0;
        clrFlags_i      = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v;
        rst_n_i         = 1'b0;
        pktIn_i         = 16'h5555;
        pktInChanged_i  = 1'b1;
        pktWetChanged_i = 1'b1;
        clrFlags_i      = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_fxchg", 32'(pktFxChanged_o), 32'd0);
        chk("rst_fx", 32'(pktFx_o), 32'd0);
        chk("rst_unf", 32'(underflow_o), 32'd0);
        pktInChanged_i  = 1'b0;
        pktWetChanged_i = 1'b0;
        rst_n_i = 1'b1;

        // First edge after release must ignore the strobe.
        drive(1'b1, 16'hAAAA, 1'b0, 1'b0);
        chk("sync_fxchg", 32'(pktFxChanged_o), 32'd0);
        chk("sync_level", 32'(level_o), 32'd0);
        idle(1);

        // Single round trip.
        drive(1'b1, 16'h1234, 1'b0, 1'b0);
        chk("t2_fx", 32'(pktFx_o), 32'h1234);
        chk("t2_fxchg", 32'(pktFxChanged_o), 32'd1);
        chk("t2_level1", 32'(level_o), 32'd1);
        idle(1);
        chk("t2_fxchg_low", 32'(pktFxChanged_o), 32'd0);
        idle(8);
        chk("t2_dry", 32'(pktDry_o), 32'h1234);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("t2_popped", 32'(pktDryPopped_o), 32'd1);
        chk("t2_level0", 32'(level_o), 32'd0);
        chk("t2_dry_empty", 32'(pktDry_o), 32'd0);

        // Fill, overflow, drain in order.
        for (int i = 1; i <= D; i++) drive(1'b1, W'(i), 1'b0, 1'b0);
        chk("t3_level", 32'(level_o), 32'd8);
        chk("t3_ovf0", 32'(overflow_o), 32'd0);
        drive(1'b1, 16'h0009, 1'b0, 1'b0);
        chk("t3_ovf", 32'(overflow_o), 32'd1);
        chk("t3_fx", 32'(pktFx_o), 32'h0009);
        chk("t3_level_full", 32'(level_o), 32'd8);
        for (int i = 1; i <= D; i++) begin
            chk("t3_drain", 32'(pktDry_o), 32'(i));
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        chk("t3_level_empty", 32'(level_o), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("t3_ovf_clr", 32'(overflow_o), 32'd0);

        // Underflow, clear, and set-beats-clear.
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("t4_unf", 32'(underflow_o), 32'd1);
        chk("t4_nopop", 32'(pktDryPopped_o), 32'd0);
        chk("t4_dry", 32'(pktDry_o), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("t4_unf_clr", 32'(underflow_o), 32'd0);
        drive(1'b0, '0, 1'b1, 1'b1);
        chk("t4_set_wins", 32'(underflow_o), 32'd1);
        drive(1'b1, 16'hBEEF, 1'b1, 1'b1);
        chk("t4_emp_pp_lvl", 32'(level_o), 32'd1);
        chk("t4_emp_pp_unf", 32'(underflow_o), 32'd1);
        drive(1'b0, '0, 1'b1, 1'b1);
        chk("t4_lvl0", 32'(level_o), 32'd0);

        // Pointer wrap with short round trips.
        for (int i = 0; i < 20; i++) begin
            v = W'($urandom);
            drive(1'b1, v, 1'b0, 1'b0);
            idle(2);
            chk("t5_dry", 32'(pktDry_o), 32'(v));
            chk("t5_level", 32'(level_o), 32'd1);
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        for (int i = 0; i < D; i++) drive(1'b1, W'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, W'($urandom), 1'b1, 1'b0);
            chk("t5_full_lvl", 32'(level_o), 32'd8);
            chk("t5_full_ovf", 32'(overflow_o), 32'd0);
        end
        for (int i = 0; i < D; i++) drive(1'b0, '0, 1'b1, 1'b0);

        // Mid-stream asynchronous reset.
        for (int i = 0; i < 5; i++) drive(1'b1, W'($urandom), 1'b0, 1'b0);
        chk("t6_level5", 32'(level_o), 32'd5);
        #1 rst_n_i = 1'b0;
        #1;
        chk("t6_async_lvl", 32'(level_o), 32'd0);
        chk("t6_async_fx", 32'(pktFx_o), 32'd0);
        chk("t6_async_dry", 32'(pktDry_o), 32'd0);
        @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        idle(1);
        drive(1'b1, 16'hC0DE, 1'b0, 1'b0);
        chk("t6_push", 32'(level_o), 32'd1);
        chk("t6_dry", 32'(pktDry_o), 32'hC0DE);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("t6_pop", 32'(pktDryPopped_o), 32'd1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 99) < 50), W'($urandom),
                  1'($urandom_range(0, 99) < 45),
                  1'($urandom_range(0, 99) < 5));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
